// File: rtl/gpio_register_file_pkg.sv
// Shared field positions and FSM encoding for the MicroBlaze GPIO register link.
package gpio_register_file_pkg;

  localparam int REQ_BIT  = 31;
  localparam int WR_BIT   = 30;
  localparam int ADDR_LSB = 24;
  localparam int DATA_LSB = 0;
  localparam int ACK_BIT  = 31;
  localparam int ERR_BIT  = 30;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    ACK  = 2'd2
  } state_t;

endpackage

// File: rtl/gpio_rf_regs.sv
// Read/write control registers for the DSP datapath, with a one-cycle strobe per write.
module gpio_rf_regs
  import gpio_register_file_pkg::*;
#(
  parameter int NB_DATA = 16,
  parameter int NB_ADDR = 4,
  parameter int N_RW    = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wr_en,
  input  logic [NB_ADDR-1:0]      addr,
  input  logic [NB_DATA-1:0]      wdata,
  output logic [N_RW*NB_DATA-1:0] rw_regs,
  output logic [N_RW-1:0]         wr_pulse
);

  genvar gi;
  generate
    for (gi = 0; gi < N_RW; gi++) begin : g_reg
      logic               hit;
      logic [NB_DATA-1:0] data_reg;
      logic               pulse_reg;

      assign hit = wr_en && (addr == NB_ADDR'(gi));

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          data_reg  <= '0;
          pulse_reg <= 1'b0;
        end else begin
          pulse_reg <= hit;
          if (hit) data_reg <= wdata;
        end
      end

      assign rw_regs[gi*NB_DATA +: NB_DATA] = data_reg;
      assign wr_pulse[gi]                   = pulse_reg;
    end
  endgenerate

endmodule

// File: rtl/gpio_register_file.sv
// GPIO link responder: registers the request word, runs the req/ack handshake
// and executes one register access per request.
module gpio_register_file
  import gpio_register_file_pkg::*;
#(
  parameter int NB_GPIOS = 32,
  parameter int NB_DATA  = 16,
  parameter int NB_ADDR  = 4,
  parameter int N_RW     = 4,
  parameter int N_RO     = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NB_GPIOS-1:0]     i_gpo,
  output logic [NB_GPIOS-1:0]     o_gpi,
  output logic [N_RW*NB_DATA-1:0] o_rw_regs,
  output logic [N_RW-1:0]         o_wr_pulse,
  input  logic [N_RO*NB_DATA-1:0] i_ro_regs
);

  state_t               state_reg, state_next;
  logic [NB_GPIOS-1:0]  gpo_q_reg;
  logic                 wr_reg;
  logic [NB_ADDR-1:0]   addr_reg;
  logic [NB_DATA-1:0]   wdata_reg;
  logic [NB_DATA-1:0]   rdata_reg, rdata_next;
  logic                 err_reg, err_next;
  logic                 ack_reg;
  logic                 latch_en, exec_en;
  logic                 hit_rw, hit_ro;
  logic [NB_DATA-1:0]   rd_mux;
  logic                 unused_bits;

  logic [NB_DATA-1:0] rw_array [N_RW];
  logic [NB_DATA-1:0] ro_array [N_RO];

  genvar gi;
  generate
    for (gi = 0; gi < N_RW; gi++) begin : g_rw_view
      assign rw_array[gi] = o_rw_regs[gi*NB_DATA +: NB_DATA];
    end
    for (gi = 0; gi < N_RO; gi++) begin : g_ro_view
      assign ro_array[gi] = i_ro_regs[gi*NB_DATA +: NB_DATA];
    end
  endgenerate

  assign unused_bits = ^{gpo_q_reg[WR_BIT-1 : ADDR_LSB+NB_ADDR],
                         gpo_q_reg[ADDR_LSB-1 : DATA_LSB+NB_DATA]};

  always_comb begin
    state_next = state_reg;
    latch_en   = 1'b0;
    exec_en    = 1'b0;
    case (state_reg)
      IDLE: if (gpo_q_reg[REQ_BIT]) begin
        state_next = EXEC;
        latch_en   = 1'b1;
      end
      EXEC: begin
        state_next = ACK;
        exec_en    = 1'b1;
      end
      ACK:     if (!gpo_q_reg[REQ_BIT]) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Address decode: RW block first, RO block directly above it.
  always_comb begin
    hit_rw = 1'b0;
    hit_ro = 1'b0;
    rd_mux = '0;
    for (int k = 0; k < N_RW; k++) begin
      if (addr_reg == NB_ADDR'(k)) begin
        hit_rw = 1'b1;
        rd_mux = rw_array[k];
      end
    end
    for (int k = 0; k < N_RO; k++) begin
      if (addr_reg == NB_ADDR'(N_RW + k)) begin
        hit_ro = 1'b1;
        rd_mux = ro_array[k];
      end
    end
  end

  always_comb begin
    err_next   = wr_reg ? !hit_rw : !(hit_rw || hit_ro);
    rdata_next = '0;
    if (!err_next) rdata_next = wr_reg ? wdata_reg : rd_mux;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      gpo_q_reg <= '0;
      wr_reg    <= 1'b0;
      addr_reg  <= '0;
      wdata_reg <= '0;
      rdata_reg <= '0;
      err_reg   <= 1'b0;
      ack_reg   <= 1'b0;
    end else begin
      gpo_q_reg <= i_gpo;
      state_reg <= state_next;
      ack_reg   <= (state_next == ACK);
      if (latch_en) begin
        wr_reg    <= gpo_q_reg[WR_BIT];
        addr_reg  <= gpo_q_reg[ADDR_LSB +: NB_ADDR];
        wdata_reg <= gpo_q_reg[DATA_LSB +: NB_DATA];
      end
      // rdata/err persist past ack so the micro can read them late.
      if (exec_en) begin
        rdata_reg <= rdata_next;
        err_reg   <= err_next;
      end
    end
  end

  always_comb begin
    o_gpi                      = '0;
    o_gpi[ACK_BIT]             = ack_reg;
    o_gpi[ERR_BIT]             = err_reg;
    o_gpi[DATA_LSB +: NB_DATA] = rdata_reg;
  end

  gpio_rf_regs #(
    .NB_DATA (NB_DATA),
    .NB_ADDR (NB_ADDR),
    .N_RW    (N_RW)
  ) u_regs (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (exec_en && wr_reg && hit_rw),
    .addr     (addr_reg),
    .wdata    (wdata_reg),
    .rw_regs  (o_rw_regs),
    .wr_pulse (o_wr_pulse)
  );

endmodule

// File: tb/tb_gpio_register_file.sv
// Scenario bench for gpio_register_file: a queue of expected responses is
// filled as each request is driven and drained when ack arrives.
module tb_gpio_register_file;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] i_gpo;
  logic [31:0] o_gpi;
  logic [63:0] o_rw_regs;
  logic [3:0]  o_wr_pulse;
  logic [63:0] i_ro_regs;

  always #5 clk = ~clk;

  gpio_register_file #(
    .NB_GPIOS (32),
    .NB_DATA  (16),
    .NB_ADDR  (4),
    .N_RW     (4),
    .N_RO     (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .i_gpo      (i_gpo),
    .o_gpi      (o_gpi),
    .o_rw_regs  (o_rw_regs),
    .o_wr_pulse (o_wr_pulse),
    .i_ro_regs  (i_ro_regs)
  );

  typedef struct {
    logic        err;
    logic [15:0] rdata;
    logic [3:0]  pulse;
  } exp_t;

  exp_t        sb_q[$];
  logic [15:0] model_regs [4];
  int          pass_cnt  = 0;
  int          total_cnt = 0;

  function automatic logic [63:0] model_flat();
    logic [63:0] f;
    for (int k = 0; k < 4; k++) f[k*16 +: 16] = model_regs[k];
    return f;
  endfunction

  task automatic send(input logic wr, input logic [3:0] addr, input logic [15:0] data,
                      output int lat, output logic [31:0] rsp, output logic [3:0] pls);
    @(posedge clk);
    #1 i_gpo = {1'b1, wr, 2'b00, addr, 8'h00, data};
    lat = 0;
    do begin
      @(posedge clk);
      #1 lat++;
    end while (!o_gpi[31] && lat < 20);
    rsp = o_gpi;
    pls = o_wr_pulse;
    $display("txn wr=%0b addr=%0d data=%h -> rsp=%h pulse=%b lat=%0d", wr, addr, data, rsp, pls, lat);
  endtask

  task automatic release_req(output int lat, output logic [3:0] pls_after);
    @(posedge clk);
    #1 pls_after = o_wr_pulse;
    i_gpo[31] = 1'b0;
    lat = 0;
    do begin
      @(posedge clk);
      #1 lat++;
    end while (o_gpi[31] && lat < 20);
  endtask

  task automatic test_reset();
    int          lat;
    logic [31:0] rsp;
    logic [3:0]  pls;
    rst = 1'b1;
    i_gpo = '0;
    i_ro_regs = '0;
    for (int k = 0; k < 4; k++) model_regs[k] = '0;
    repeat (2) @(posedge clk);
    #1;
    total_cnt++;
    if (o_gpi !== 32'h0) $display("FAIL reset_gpi: got %h expected 0", o_gpi); else pass_cnt++;
    total_cnt++;
    if (o_rw_regs !== 64'h0) $display("FAIL reset_regs: got %h expected 0", o_rw_regs); else pass_cnt++;
    total_cnt++;
    if (o_wr_pulse !== 4'h0) $display("FAIL reset_pulse: got %b expected 0", o_wr_pulse); else pass_cnt++;
    rst = 1'b0;

    // Park in ACK holding a write, then hit reset between clock edges.
    send(1'b1, 4'd0, 16'h5555, lat, rsp, pls);
    #3 rst = 1'b1;
    #1;
    for (int k = 0; k < 4; k++) model_regs[k] = '0;
    total_cnt++;
    if (o_gpi !== 32'h0) $display("FAIL async_reset_gpi: got %h expected 0", o_gpi); else pass_cnt++;
    total_cnt++;
    if (o_rw_regs !== model_flat()) $display("FAIL async_reset_regs: got %h expected %h", o_rw_regs, model_flat()); else pass_cnt++;

    // req stays high, so the same write replays as a fresh transaction.
    model_regs[0] = 16'h5555;
    sb_q.push_back('{1'b0, 16'h5555, 4'b0001});
    @(posedge clk);
    #1 rst = 1'b0;
    lat = 0;
    do begin
      @(posedge clk);
      #1 lat++;
    end while (!o_gpi[31] && lat < 20);
    begin
      exp_t e = sb_q.pop_front();
      total_cnt++;
      if (lat != 3) $display("FAIL replay_latency: got %0d expected 3", lat); else pass_cnt++;
      total_cnt++;
      if (o_wr_pulse !== e.pulse) $display("FAIL replay_pulse: got %b expected %b", o_wr_pulse, e.pulse); else pass_cnt++;
      total_cnt++;
      if (o_gpi !== {1'b1, e.err, 14'h0, e.rdata}) $display("FAIL replay_rsp: got %h expected %h", o_gpi, {1'b1, e.err, 14'h0, e.rdata}); else pass_cnt++;
    end
    release_req(lat, pls);
    total_cnt++;
    if (o_rw_regs !== model_flat()) $display("FAIL replay_regs: got %h expected %h", o_rw_regs, model_flat()); else pass_cnt++;
  endtask

  task automatic test_write();
    int          lat;
    logic [31:0] rsp;
    logic [3:0]  pls;
    exp_t        e;
    model_regs[2] = 16'hBEEF;
    sb_q.push_back('{1'b0, 16'hBEEF, 4'b0100});
    send(1'b1, 4'd2, 16'hBEEF, lat, rsp, pls);
    e = sb_q.pop_front();
    total_cnt++;
    if (lat != 3) $display("FAIL write_latency: got %0d expected 3", lat); else pass_cnt++;
    total_cnt++;
    if (rsp !== {1'b1, e.err, 14'h0, e.rdata}) $display("FAIL write_rsp: got %h expected %h", rsp, {1'b1, e.err, 14'h0, e.rdata}); else pass_cnt++;
    total_cnt++;
    if (pls !== e.pulse) $display("FAIL write_pulse: got %b expected %b", pls, e.pulse); else pass_cnt++;
    total_cnt++;
    if (o_rw_regs !== model_flat()) $display("FAIL write_regs: got %h expected %h", o_rw_regs, model_flat()); else pass_cnt++;
    release_req(lat, pls);
    total_cnt++;
    if (pls !== 4'h0) $display("FAIL write_pulse_width: got %b expected 0000", pls); else pass_cnt++;
    total_cnt++;
    if (lat != 2) $display("FAIL write_release_latency: got %0d expected 2", lat); else pass_cnt++;
    total_cnt++;
    if (o_gpi !== {2'b00, 14'h0, e.rdata}) $display("FAIL write_rdata_hold: got %h expected %h", o_gpi, {2'b00, 14'h0, e.rdata}); else pass_cnt++;
  endtask

  task automatic test_read();
    int          lat;
    logic [31:0] rsp;
    logic [3:0]  pls;
    logic [3:0]  addrs [3];
    exp_t        e;
    addrs = '{4'd2, 4'd5, 4'd7};
    i_ro_regs = {16'hC0DE, 16'hA5A5, 16'h1234, 16'h0F0F};
    for (int t = 0; t < 3; t++) begin
      logic [15:0] want;
      want = (addrs[t] < 4) ? model_regs[addrs[t]] : i_ro_regs[(addrs[t] - 4) * 16 +: 16];
      sb_q.push_back('{1'b0, want, 4'b0000});
      send(1'b0, addrs[t], 16'hFFFF, lat, rsp, pls);
      e = sb_q.pop_front();
      total_cnt++;
      if (rsp !== {1'b1, e.err, 14'h0, e.rdata}) $display("FAIL read_rsp addr=%0d: got %h expected %h", addrs[t], rsp, {1'b1, e.err, 14'h0, e.rdata}); else pass_cnt++;
      total_cnt++;
      if (pls !== e.pulse) $display("FAIL read_pulse addr=%0d: got %b expected %b", addrs[t], pls, e.pulse); else pass_cnt++;
      release_req(lat, pls);
    end
  endtask

  task automatic test_errors();
    int          lat;
    logic [31:0] rsp;
    logic [3:0]  pls;
    logic        wrs   [3];
    logic [3:0]  addrs [3];
    exp_t        e;
    wrs   = '{1'b1, 1'b0, 1'b1};
    addrs = '{4'd6, 4'd9, 4'd15};
    for (int t = 0; t < 3; t++) begin
      sb_q.push_back('{1'b1, 16'h0000, 4'b0000});
      send(wrs[t], addrs[t], 16'hAAAA, lat, rsp, pls);
      e = sb_q.pop_front();
      total_cnt++;
      if (rsp !== {1'b1, e.err, 14'h0, e.rdata}) $display("FAIL err_rsp addr=%0d: got %h expected %h", addrs[t], rsp, {1'b1, e.err, 14'h0, e.rdata}); else pass_cnt++;
      total_cnt++;
      if (pls !== e.pulse) $display("FAIL err_pulse addr=%0d: got %b expected %b", addrs[t], pls, e.pulse); else pass_cnt++;
      total_cnt++;
      if (o_rw_regs !== model_flat()) $display("FAIL err_regs addr=%0d: got %h expected %h", addrs[t], o_rw_regs, model_flat()); else pass_cnt++;
      release_req(lat, pls);
    end
  endtask

  task automatic test_hold();
    int          lat;
    int          pulse_cnt;
    logic [3:0]  pls;
    exp_t        e;
    model_regs[1] = 16'h1111;
    sb_q.push_back('{1'b0, 16'h1111, 4'b0010});
    pulse_cnt = 0;
    @(posedge clk);
    #1 i_gpo = {1'b1, 1'b1, 2'b00, 4'd1, 8'h00, 16'h1111};
    for (int c = 0; c < 20; c++) begin
      @(posedge clk);
      #1 pulse_cnt += $countones(o_wr_pulse);
      i_gpo[15:0] = 16'($urandom);
      i_gpo[27:24] = 4'($urandom_range(0, 3));
    end
    e = sb_q.pop_front();
    total_cnt++;
    if (o_gpi !== {1'b1, e.err, 14'h0, e.rdata}) $display("FAIL hold_rsp: got %h expected %h", o_gpi, {1'b1, e.err, 14'h0, e.rdata}); else pass_cnt++;
    release_req(lat, pls);
    total_cnt++;
    if (lat != 2) $display("FAIL hold_release_latency: got %0d expected 2", lat); else pass_cnt++;
    repeat (4) begin
      @(posedge clk);
      #1 pulse_cnt += $countones(o_wr_pulse);
    end
    total_cnt++;
    if (pulse_cnt != 1) $display("FAIL hold_pulse_count: got %0d expected 1", pulse_cnt); else pass_cnt++;
    total_cnt++;
    if (o_rw_regs !== model_flat()) $display("FAIL hold_regs: got %h expected %h", o_rw_regs, model_flat()); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    int          lat;
    logic [31:0] rsp;
    logic [3:0]  pls;
    logic [15:0] d;
    exp_t        e;
    for (int t = 0; t < 4; t++) begin
      d = 16'($urandom);
      model_regs[t] = d;
      sb_q.push_back('{1'b0, d, 4'(1 << t)});
      send(1'b1, 4'(t), d, lat, rsp, pls);
      e = sb_q.pop_front();
      total_cnt++;
      if (lat != 3) $display("FAIL b2b_latency txn=%0d: got %0d expected 3", t, lat); else pass_cnt++;
      total_cnt++;
      if (pls !== e.pulse) $display("FAIL b2b_pulse txn=%0d: got %b expected %b", t, pls, e.pulse); else pass_cnt++;
      total_cnt++;
      if (rsp !== {1'b1, e.err, 14'h0, e.rdata}) $display("FAIL b2b_rsp txn=%0d: got %h expected %h", t, rsp, {1'b1, e.err, 14'h0, e.rdata}); else pass_cnt++;
      release_req(lat, pls);
      total_cnt++;
      if (pls !== 4'h0) $display("FAIL b2b_pulse_width txn=%0d: got %b expected 0000", t, pls); else pass_cnt++;
    end
    total_cnt++;
    if (o_rw_regs !== model_flat()) $display("FAIL b2b_regs: got %h expected %h", o_rw_regs, model_flat()); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_errors();
    test_hold();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/gpio_register_file.md
# gpio_register_file

Responder side of the MicroBlaze GPIO link. The micro acts as initiator: it drives a request word on the 32-bit GPIO output bus and reads completion on the 32-bit GPIO input bus. This block decodes each request with a 4-phase req/ack handshake, executes it against a small register file, and returns ack, error flag and read data. It sits between the MicroBlaze GPIO port and the DSP datapath. The RW registers drive DSP controls; the RO registers expose DSP status.

## Interface
- NB_GPIOS, 32, width of the GPIO buses.
- NB_DATA, 16, register data width.
- NB_ADDR, 4, address field width.
- N_RW, 4, number of read/write registers.
- N_RO, 4, number of read-only registers.

Ports (one clock; `rst` is asynchronous, active-high):
- clk  in  1  clock, same domain as the micro GPIO.
- rst  in  1  asynchronous, active-high reset.
- i_gpo  in  NB_GPIOS  request word from the micro.
- o_gpi  out  NB_GPIOS  response word to the micro.
- o_rw_regs  out  N_RW*NB_DATA  RW register contents; reg k occupies bits [k*NB_DATA +: NB_DATA].
- o_wr_pulse  out  N_RW  one-cycle strobe, bit k set when reg k is written.
- i_ro_regs  in  N_RO*NB_DATA  status values returned for RO reads.

## Operation

Request word fields:
- i_gpo[31] = req (level).
- i_gpo[30] = wr (1 = write).
- i_gpo[29:28] reserved, ignored.
- i_gpo[27:24] = addr.
- i_gpo[23:16] reserved.
- i_gpo[15:0] = wdata.

Response word fields:
- o_gpi[31] = ack.
- o_gpi[30] = err.
- o_gpi[29:16] = 0.
- o_gpi[15:0] = rdata.

Address map:
- 0..N_RW-1: RW registers.
- N_RW..N_RW+N_RO-1: RO registers, mapped to i_ro_regs index (addr−N_RW).
- All other addresses: invalid.

Input stage: i_gpo is registered into gpo_q every cycle. The FSM acts only on gpo_q.

FSM states:
- IDLE: ack=0. If gpo_q.req=1, latch wr/addr/wdata and go to EXEC.
- EXEC (exactly 1 cycle), then go to ACK:
  - Valid RW write: reg updated; matching o_wr_pulse bit high; err=0; rdata=wdata.
  - Valid read: rdata = reg value (RO values sampled this cycle); err=0.
  - Write to RO or invalid address: no register change; no pulse; err=1; rdata=0.
- ACK: ack=1. Stay while gpo_q.req=1; go to IDLE when gpo_q.req=0.

Additional rules:
- rdata and err hold from EXEC until the next EXEC, so they remain valid after ack drops.
- Field changes while in ACK are ignored; only the fields latched at IDLE→EXEC are used.
- A new request is accepted only after ack has dropped (req must be seen low in ACK).

Reset (asynchronous): state=IDLE, gpo_q=0, all RW regs=0, o_wr_pulse=0, o_gpi=0. If req is still high when reset releases, that request executes again as a fresh transaction.

## Timing
- Latency, req high at i_gpo (edge n): gpo_q at n+1, EXEC at n+2, ack=1 at n+3.
- Write effect: the RW register and o_wr_pulse change at edge n+3; the pulse lasts one cycle.
- Release, req low at i_gpo (edge m, state ACK): gpo_q at m+1, ack=0 at m+2.
- Minimum transaction: 5 cycles.
- All outputs are registered; there are no combinational paths from i_gpo to o_gpi.

## Structure
Shared include/package holds:
- Bit-position constants: REQ_BIT, WR_BIT, ADDR_LSB, DATA_LSB, ACK_BIT, ERR_BIT.
- State encodings: IDLE=2'd0, EXEC=2'd1, ACK=2'd2; 2'd3 recovers to IDLE.

Sub-module gpio_rf_regs holds the RW array, write decode and pulse generation. The top-level block contains the input register, FSM and read mux.

## Test plan
- Reset: assert rst mid-ACK → o_gpi=0, all o_rw_regs=0 immediately (asynchronous); with req still high after release, ack reasserts 3 cycles later.
- Write: write addr 2, data 0xBEEF → ack at n+3; reg2=0xBEEF; o_wr_pulse=4'b0100 for exactly one cycle; err=0; other regs unchanged.
- Read RW and RO: read addr 2 → rdata=0xBEEF. Drive i_ro_regs slot 1 = 0x1234, read addr 5 → rdata=0x1234, err=0.
- Errors: write addr 6 → err=1, rdata=0, no pulse, no register change. Read addr 9 → err=1, rdata=0.
- Handshake integrity: hold req high for 20 cycles while changing wdata → exactly one write with the latched data; ack drops 2 cycles after req drops; back-to-back requests each produce one pulse.
